// File: rtl/fault_latch_ctrl.sv
// Protection fault manager: latches the first-fault snapshot, holds PWM off for a
// minimum time, re-enables on a DSP clear handshake, and locks out after repeated trips.
module fault_latch_ctrl #(
    parameter int unsigned N_FLT     = 4,
    parameter int unsigned HOLD_CYC  = 1000,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned CLEAN_CYC = 4096
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic [N_FLT-1:0] Flt_n,
    input  logic             Clr_req,
    output logic             Pwm_en,
    output logic             Clr_ack,
    output logic [N_FLT-1:0] Flt_code,
    output logic             Flt_any,
    output logic             Lockout,
    output logic [3:0]       Trip_cnt
);

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        WAIT_CLR,
        LOCK
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
    localparam logic [15:0] CLEAN_LIM = 16'(CLEAN_CYC);
    localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

    state_t           state, state_nx;
    logic [15:0]      hold_cnt, hold_cnt_nx;
    logic [15:0]      clean_cnt, clean_cnt_nx;
    logic [3:0]       trip_cnt_nx;
    logic [N_FLT-1:0] code_nx;
    logic             pwm_nx, ack_nx;
    logic             s1, s2, s3;
    logic             clr_edge;
    logic             fault_any;

    assign clr_edge  = s2 & ~s3;
    assign fault_any = ~&Flt_n;
    assign Flt_any   = (state != RUN);
    assign Lockout   = (state == LOCK);

    // Synchroniser resets high so a request already held at reset is not an edge.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= Clr_req;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state     <= RUN;
            hold_cnt  <= '0;
            clean_cnt <= '0;
            Trip_cnt  <= '0;
            Flt_code  <= '0;
            Pwm_en    <= 1'b1;
            Clr_ack   <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_cnt_nx;
            clean_cnt <= clean_cnt_nx;
            Trip_cnt  <= trip_cnt_nx;
            Flt_code  <= code_nx;
            Pwm_en    <= pwm_nx;
            Clr_ack   <= ack_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        hold_cnt_nx  = hold_cnt;
        clean_cnt_nx = clean_cnt;
        trip_cnt_nx  = Trip_cnt;
        code_nx      = Flt_code;
        ack_nx       = 1'b0;

        case (state)
            RUN: begin
                // A trip takes priority over the clean window expiring on the same edge.
                if (fault_any) begin
                    state_nx     = HOLD;
                    code_nx      = ~Flt_n;
                    trip_cnt_nx  = (Trip_cnt == 4'hF) ? Trip_cnt : Trip_cnt + 4'd1;
                    hold_cnt_nx  = '0;
                    clean_cnt_nx = '0;
                end else begin
                    if (clean_cnt != CLEAN_LIM) begin
                        clean_cnt_nx = clean_cnt + 16'd1;
                    end
                    if (clean_cnt_nx == CLEAN_LIM) begin
                        trip_cnt_nx = '0;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = (Trip_cnt >= RETRY_LIM) ? LOCK : WAIT_CLR;
                end else begin
                    hold_cnt_nx = hold_cnt + 16'd1;
                end
            end
            WAIT_CLR: begin
                if (clr_edge && !fault_any) begin
                    state_nx     = RUN;
                    ack_nx       = 1'b1;
                    code_nx      = '0;
                    clean_cnt_nx = '0;
                end
            end
            LOCK: begin
                state_nx = LOCK;
            end
            default: begin
                state_nx = RUN;
            end
        endcase

        pwm_nx = (state_nx == RUN);
    end

endmodule

// File: tb/tb_fault_latch_ctrl.sv
// Table-driven bench for fault_latch_ctrl with a due-cycle scoreboard queue,
// plus a hand-written clear-handshake latency sequence.
module tb_fault_latch_ctrl;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [3:0] flt;
        logic       clr;
        int         cyc;
        logic       pwm;
        logic       ack;
        logic [3:0] code;
        logic       any;
        logic       lock;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        int   due;
        vec_t v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] flt_n;
    logic       clr_req;
    logic       pwm_en;
    logic       clr_ack;
    logic [3:0] flt_code;
    logic       flt_any;
    logic       lockout;
    logic [3:0] trip_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    exp_t sb[$];
    exp_t cur;
    vec_t vecs[$];

    fault_latch_ctrl #(
        .N_FLT(4),
        .HOLD_CYC(8),
        .MAX_RETRY(3),
        .CLEAN_CYC(32)
    ) dut (
        .clk(clk),
        .Rst_n(rst_n),
        .Flt_n(flt_n),
        .Clr_req(clr_req),
        .Pwm_en(pwm_en),
        .Clr_ack(clr_ack),
        .Flt_code(flt_code),
        .Flt_any(flt_any),
        .Lockout(lockout),
        .Trip_cnt(trip_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(string name, logic r, logic [3:0] f, logic c, int n,
                                logic p, logic a, logic [3:0] cd, logic y, logic l,
                                logic [3:0] t);
        vec_t v;
        v.name = name; v.rst_n = r; v.flt = f; v.clr = c; v.cyc = n;
        v.pwm = p; v.ack = a; v.code = cd; v.any = y; v.lock = l; v.cnt = t;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic apply(vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n   = v.rst_n;
        flt_n   = v.flt;
        clr_req = v.clr;
        e.due = cyc_cnt + v.cyc;
        e.v   = v;
        sb.push_back(e);
        repeat (v.cyc) @(posedge clk);
    endtask

    // Monitor: pops each expectation on the cycle it falls due.
    always @(posedge clk) begin
        cyc_cnt++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
            cur = sb.pop_front();
            chk({cur.v.name, ".pwm_en"},   int'(pwm_en),   int'(cur.v.pwm));
            chk({cur.v.name, ".clr_ack"},  int'(clr_ack),  int'(cur.v.ack));
            chk({cur.v.name, ".flt_code"}, int'(flt_code), int'(cur.v.code));
            chk({cur.v.name, ".flt_any"},  int'(flt_any),  int'(cur.v.any));
            chk({cur.v.name, ".lockout"},  int'(lockout),  int'(cur.v.lock));
            chk({cur.v.name, ".trip_cnt"}, int'(trip_cnt), int'(cur.v.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int ack_cycles;

        rst_n   = 1'b0;
        flt_n   = 4'hF;
        clr_req = 1'b0;

        //                 name            rst flt   clr cyc  pwm ack code  any lck cnt
        vecs.push_back(mk("reset",         0, 4'hF, 0,  2,   1, 0, 4'h0, 0, 0, 4'd0));
        vecs.push_back(mk("run_idle",      1, 4'hF, 0,  5,   1, 0, 4'h0, 0, 0, 4'd0));
        vecs.push_back(mk("trip_b",        1, 4'hB, 0,  1,   0, 0, 4'h4, 1, 0, 4'd1));
        vecs.push_back(mk("hold_mid",      1, 4'hF, 0,  5,   0, 0, 4'h4, 1, 0, 4'd1));
        vecs.push_back(mk("hold_clr_drop", 1, 4'hF, 1,  3,   0, 0, 4'h4, 1, 0, 4'd1));
        vecs.push_back(mk("clr_held",      1, 4'hF, 1,  4,   0, 0, 4'h4, 1, 0, 4'd1));
        vecs.push_back(mk("clr_low",       1, 4'hF, 0,  3,   0, 0, 4'h4, 1, 0, 4'd1));
        vecs.push_back(mk("clr_lat1",      1, 4'hF, 1,  2,   0, 0, 4'h4, 1, 0, 4'd1));
        vecs.push_back(mk("clr_acc",       1, 4'hF, 1,  1,   1, 1, 4'h0, 0, 0, 4'd1));
        vecs.push_back(mk("ack_end",       1, 4'hF, 1,  1,   1, 0, 4'h0, 0, 0, 4'd1));
        vecs.push_back(mk("trip_e",        1, 4'hE, 0,  1,   0, 0, 4'h1, 1, 0, 4'd2));
        vecs.push_back(mk("hold_ign",      1, 4'hD, 0,  9,   0, 0, 4'h1, 1, 0, 4'd2));
        vecs.push_back(mk("clr_flt",       1, 4'hE, 1,  4,   0, 0, 4'h1, 1, 0, 4'd2));
        vecs.push_back(mk("clr_nonew",     1, 4'hF, 1,  4,   0, 0, 4'h1, 1, 0, 4'd2));
        vecs.push_back(mk("clr_low2",      1, 4'hF, 0,  3,   0, 0, 4'h1, 1, 0, 4'd2));
        vecs.push_back(mk("clr_acc2",      1, 4'hF, 1,  3,   1, 1, 4'h0, 0, 0, 4'd2));
        vecs.push_back(mk("ack_end2",      1, 4'hF, 0,  1,   1, 0, 4'h0, 0, 0, 4'd2));
        vecs.push_back(mk("trip_6",        1, 4'h6, 0,  1,   0, 0, 4'h9, 1, 0, 4'd3));
        vecs.push_back(mk("hold_last",     1, 4'hF, 0,  7,   0, 0, 4'h9, 1, 0, 4'd3));
        vecs.push_back(mk("lock",          1, 4'hF, 0,  1,   0, 0, 4'h9, 1, 1, 4'd3));
        vecs.push_back(mk("lock_clr",      1, 4'hF, 1,  4,   0, 0, 4'h9, 1, 1, 4'd3));
        vecs.push_back(mk("lock_flt",      1, 4'h0, 0,  3,   0, 0, 4'h9, 1, 1, 4'd3));
        vecs.push_back(mk("lock_rst",      0, 4'hF, 0,  1,   1, 0, 4'h0, 0, 0, 4'd0));
        vecs.push_back(mk("run3",          1, 4'hF, 0,  3,   1, 0, 4'h0, 0, 0, 4'd0));
        vecs.push_back(mk("trip_7",        1, 4'h7, 0,  1,   0, 0, 4'h8, 1, 0, 4'd1));
        vecs.push_back(mk("hold3",         1, 4'hF, 0,  8,   0, 0, 4'h8, 1, 0, 4'd1));
        vecs.push_back(mk("clr_acc3",      1, 4'hF, 1,  3,   1, 1, 4'h0, 0, 0, 4'd1));
        vecs.push_back(mk("clean31",       1, 4'hF, 0, 31,   1, 0, 4'h0, 0, 0, 4'd1));
        vecs.push_back(mk("clean32",       1, 4'hF, 0,  1,   1, 0, 4'h0, 0, 0, 4'd0));
        vecs.push_back(mk("clean_sat",     1, 4'hF, 0,  5,   1, 0, 4'h0, 0, 0, 4'd0));
        vecs.push_back(mk("trip_b2",       1, 4'hB, 0,  1,   0, 0, 4'h4, 1, 0, 4'd1));
        vecs.push_back(mk("hold4",         1, 4'hF, 0,  8,   0, 0, 4'h4, 1, 0, 4'd1));
        vecs.push_back(mk("clr_acc4",      1, 4'hF, 1,  3,   1, 1, 4'h0, 0, 0, 4'd1));
        vecs.push_back(mk("clean31b",      1, 4'hF, 0, 31,   1, 0, 4'h0, 0, 0, 4'd1));
        vecs.push_back(mk("trip_expire",   1, 4'hD, 0,  1,   0, 0, 4'h2, 1, 0, 4'd2));
        vecs.push_back(mk("hold5",         1, 4'hF, 0,  3,   0, 0, 4'h2, 1, 0, 4'd2));
        vecs.push_back(mk("hold_rst",      0, 4'hF, 0,  1,   1, 0, 4'h0, 0, 0, 4'd0));
        vecs.push_back(mk("post_rst",      1, 4'hF, 0,  2,   1, 0, 4'h0, 0, 0, 4'd0));

        foreach (vecs[i]) apply(vecs[i]);

        // Hand sequence: trip, ride out HOLD, then time the clear acknowledge.
        @(negedge clk);
        flt_n = 4'hB;
        @(negedge clk);
        flt_n = 4'hF;
        repeat (11) @(negedge clk);
        clr_req = 1'b1;
        lat = 0;
        ack_cycles = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (clr_ack) begin
                ack_cycles++;
                if (lat == 0) lat = n;
            end
        end
        chk("seq.ack_latency", lat, 3);
        chk("seq.ack_width", ack_cycles, 1);
        chk("seq.pwm_after_clr", int'(pwm_en), 1);
        chk("seq.trip_cnt", int'(trip_cnt), 1);

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fault_latch_ctrl.md
# fault_latch_ctrl

Protection fault manager sitting directly downstream of the per-channel protection glitch filters. Consumes their filtered active-low fault levels and latches the first-fault snapshot. Forces the PWM enable off, enforces a minimum off-time, then re-enables only on a DSP clear handshake with all faults gone. Repeated trips within a clean-run window escalate to a permanent lockout that only reset removes.

## Interface
- N_FLT, 4, number of filtered fault channels
- HOLD_CYC, 1000, minimum PWM-off time after a trip, clk cycles (1..65535)
- MAX_RETRY, 3, trips allowed before lockout (1..15)
- CLEAN_CYC, 4096, continuous fault-free RUN cycles that reset the trip counter (1..65535)

- clk  in  1  system clock
- Rst_n  in  1  reset, synchronous, active-low
- Flt_n  in  N_FLT  filtered fault levels, synchronous to clk, 0 = fault
- Clr_req  in  1  DSP clear request, asynchronous level; rising edge = request
- Pwm_en  out  1  gate-drive enable, 1 = PWM allowed
- Clr_ack  out  1  one-cycle pulse when a clear is accepted
- Flt_code  out  N_FLT  latched first-fault snapshot (1 = channel faulted at trip)
- Flt_any  out  1  1 in any state other than RUN
- Lockout  out  1  1 in LOCK
- Trip_cnt  out  4  trips since last clean-window reset

## Operation
- States: RUN, HOLD, WAIT_CLR, LOCK. Reset → RUN.
- Reset values: Pwm_en=1, Clr_ack=0, Flt_code=0, Flt_any=0, Lockout=0, Trip_cnt=0, hold/clean counters 0, Clr_req synchroniser flops s1..s3 = 1 (held-high request at reset is not an edge).
- Clr_req synchroniser: s1<=Clr_req, s2<=s1, s3<=s2; clr_edge = s2 & ~s3.
- RUN:
  - Any Flt_n bit 0 → HOLD: Pwm_en<=0, Flt_code<=~Flt_n (all simultaneous bits captured), Trip_cnt<=Trip_cnt+1, hold counter<=0.
  - Otherwise the clean counter increments, saturating at CLEAN_CYC. Reaching CLEAN_CYC sets Trip_cnt<=0.
  - A trip in the same cycle the clean counter would expire: trip wins; Trip_cnt increments from its old value; clean counter<=0.
- HOLD:
  - Pwm_en=0. Fault inputs are ignored for state purposes. clr_edge is discarded.
  - Hold counter counts 0..HOLD_CYC-1. At HOLD_CYC-1: if Trip_cnt ≥ MAX_RETRY → LOCK, else → WAIT_CLR.
- WAIT_CLR:
  - clr_edge with Flt_n all 1 → RUN: Pwm_en<=1, Clr_ack<=1 (one cycle), Flt_code<=0, clean counter<=0.
  - clr_edge with any Flt_n 0 is consumed without effect; DSP must issue a new edge.
- LOCK: Pwm_en=0, Lockout=1, Flt_code frozen. Only Rst_n exits.
- Flt_code is never modified outside the RUN→HOLD transition and the clear.
- Counters are 16-bit; Trip_cnt is 4-bit saturating at 15.

## Timing
- Trip latency: Flt_n bit low at edge k → Pwm_en=0, Flt_any=1, Flt_code valid after edge k (1 cycle).
- HOLD entered at edge k → leaves at edge k+HOLD_CYC; Pwm_en stays low at least HOLD_CYC cycles.
- Clear latency: Clr_req first sampled high at edge j (in WAIT_CLR, faults clear) → Pwm_en=1 and Clr_ack=1 after edge j+2. Clr_ack=0 after edge j+3.
- Clr_req held high across a trip produces no new edge; it must drop and rise again.
- Rst_n low at any edge, in any state: all outputs return to reset values after that edge, including during HOLD or LOCK.

## Test plan
(HOLD_CYC=8, MAX_RETRY=3, CLEAN_CYC=32)
- Flt_n=4'b1111 → 4'b1011 at edge 10 → Pwm_en=0 and Flt_code=4'b0100 after edge 10; state WAIT_CLR after edge 18; Trip_cnt=1.
- In WAIT_CLR, Flt_n restored, Clr_req rises sampled at edge 30 → Pwm_en=1 and 1-cycle Clr_ack after edge 32; Flt_code=0.
- In WAIT_CLR with Flt_n=4'b1110 still asserted, Clr_req pulse → no ack, Pwm_en stays 0. After faults clear, a second Clr_req edge → clears.
- Three trip/clear cycles each with <32 clean RUN cycles → after the third HOLD, Lockout=1, Pwm_en=0, Clr_req ignored; only Rst_n low restores Pwm_en=1, Trip_cnt=0.
- Trip, clear, then 32 fault-free RUN cycles → Trip_cnt=0; next trip gives Trip_cnt=1. A trip on the exact 32nd cycle gives Trip_cnt=old+1.
- Simultaneous Flt_n=4'b0110 → Flt_code=4'b1001. A later Flt_n=4'b1101 during HOLD leaves Flt_code unchanged. Rst_n low mid-HOLD → all outputs at reset values next cycle.
